stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Game-flow controller that sequences the level datapath.
- Loads each level's object table from level ROM into the active-object registers, one word per cycle.
- Gates the level logic with an enable, runs the per-stage countdown, and accumulates score.
- Decides pass/fail against a per-level target. Sits between the menu/top FSM and the level renderer/hook logic.

Parameters:
- MAX_LEVEL, 3, number of levels in ROM.
- OBJECTS_COUNT, 20, objects per level.
- WORDS_PER_OBJ, 3, ROM words per object (x, y, type).
- MAX_TIME, 60, stage duration in seconds.
- TARGET_BASE, 500, score target for level 0.
- TARGET_STEP, 250, target increment per level.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startGame  in  1  one-cycle pulse from menu; starts or restarts the game
- cycleLevel  in  1  one-cycle pulse; advances to the next level after a passed stage
- oneSecPulse  in  1  one-cycle tick per second
- scoreValid  in  1  object-collected strobe
- scoreValue  in  10  value of collected object
- romAddr  out  12  level ROM read address
- romData  in  9  ROM read data, valid exactly 1 cycle after romAddr
- loadWe  out  1  write strobe into active-object table
- loadIdx  out  6  active-object table index
- loadData  out  9  word to write (equals romData)
- levelEnable  out  1  high only in PLAY
- currentLevel  out  2  level index
- timeLeft  out  9  seconds remaining
- stageScore  out  16  score this stage
- totalScore  out  16  score across stages
- stageEnded  out  1  one-cycle pulse: stage passed, not last level
- stageFailed  out  1  held high in FAILED
- lastLevelEnded  out  1  held high in DONE

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; romAddr=0.
  - Reset mid-LOAD or mid-PLAY aborts immediately; no further loadWe.
- States: IDLE, LOAD, PLAY, CHECK, WAIT_NEXT, FAILED, DONE.
- IDLE:
  - startGame -> LOAD.
  - currentLevel=0, totalScore=0.
- LOAD:
  - On entry: stageScore=0, counter k=0.
  - Each cycle: romAddr = currentLevel*OBJECTS_COUNT*WORDS_PER_OBJ + k; k increments until N-1, where N = OBJECTS_COUNT*WORDS_PER_OBJ.
  - One cycle later: loadWe=1, loadIdx=k (delayed), loadData=romData.
  - Exactly N writes, contiguous, no gaps. LOAD lasts N+1 cycles.
  - The cycle after the last write -> PLAY, with timeLeft=MAX_TIME loaded on that transition.
  - startGame, cycleLevel, scoreValid and oneSecPulse are ignored in LOAD.
- PLAY:
  - levelEnable=1.
  - scoreValid adds scoreValue to stageScore and totalScore the same cycle; both saturate at 16'hFFFF.
  - oneSecPulse with timeLeft>0: timeLeft-1.
  - oneSecPulse with timeLeft==0 -> CHECK; timeLeft stays 0 (never wraps).
  - A scoreValid in the same cycle as that final pulse is counted.
  - startGame is ignored.
- CHECK (1 cycle):
  - target = TARGET_BASE + currentLevel*TARGET_STEP; comparison is >= (equal passes).
  - stageScore >= target and currentLevel==MAX_LEVEL-1 -> DONE.
  - stageScore >= target otherwise -> WAIT_NEXT, with stageEnded=1 for exactly this transition cycle.
  - Else -> FAILED.
  - levelEnable=0.
- WAIT_NEXT: cycleLevel -> currentLevel+1, then LOAD. Other inputs are ignored.
- FAILED: stageFailed=1, held. startGame -> LOAD with currentLevel=0, totalScore=0; stageFailed clears.
- DONE: lastLevelEnded=1, held. startGame -> restart as from FAILED.
- Simultaneous startGame and cycleLevel in WAIT_NEXT: cycleLevel wins.
- Outputs are registered; levelEnable rises the cycle after the final loadWe.

Test Plan:
(bench uses OBJECTS_COUNT=2, MAX_LEVEL=2, MAX_TIME=3, TARGET_BASE=10, TARGET_STEP=5; ROM word i = i)
1. Reset, then startGame:
   - romAddr 0..5 on consecutive cycles.
   - loadWe high 6 cycles, loadIdx 0..5, loadData 0..5.
   - levelEnable=1 next cycle, timeLeft=3.
2. In PLAY, scoreValid values 4 and 6, then 4 oneSecPulses:
   - timeLeft 3->2->1->0->0, stageScore=10.
   - 10>=10, so stageEnded is a 1-cycle pulse; state WAIT_NEXT, levelEnable=0.
3. cycleLevel:
   - currentLevel=1, romAddr 6..11, stageScore=0, totalScore=10.
   - Then score 14 and time out -> 14<15: stageFailed held, lastLevelEnded=0.
4. Level 1 scoring 15 instead:
   - lastLevelEnded=1 held, totalScore=25.
   - startGame -> currentLevel=0, totalScore=0, reload starts at romAddr 0.
5. Assert reset during LOAD cycle 3:
   - all outputs 0 the same cycle, no further loadWe.
   - startGame after release restarts at romAddr 0.
6. Final oneSecPulse coincident with scoreValid 10 at stageScore 0: the score is counted and the stage passes.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Bus bundle between the game-flow sequencer and its surroundings
// (menu FSM, level ROM, active-object table, level renderer).
// The master side drives the control pulses and ROM data.
// The slave side is the sequencer.
interface stage_sequencer_if;
    logic        startGame;
    logic        cycleLevel;
    logic        oneSecPulse;
    logic        scoreValid;
    logic [9:0]  scoreValue;
    logic [11:0] romAddr;
    logic [8:0]  romData;
    logic        loadWe;
    logic [5:0]  loadIdx;
    logic [8:0]  loadData;
    logic        levelEnable;
    logic [1:0]  currentLevel;
    logic [8:0]  timeLeft;
    logic [15:0] stageScore;
    logic [15:0] totalScore;
    logic        stageEnded;
    logic        stageFailed;
    logic        lastLevelEnded;

    modport master (
        output startGame, cycleLevel, oneSecPulse, scoreValid, scoreValue, romData,
        input  romAddr, loadWe, loadIdx, loadData, levelEnable, currentLevel,
               timeLeft, stageScore, totalScore, stageEnded, stageFailed, lastLevelEnded
    );

    modport slave (
        input  startGame, cycleLevel, oneSecPulse, scoreValid, scoreValue, romData,
        output romAddr, loadWe, loadIdx, loadData, levelEnable, currentLevel,
               timeLeft, stageScore, totalScore, stageEnded, stageFailed, lastLevelEnded
    );
endinterface

// File: rtl/stage_sequencer.sv
// Game-flow controller: copies each level's object table from ROM into the
// active-object registers, runs the stage countdown, accumulates score and
// decides pass/fail against a per-level target.
module stage_sequencer #(
    parameter int MAX_LEVEL     = 3,
    parameter int OBJECTS_COUNT = 20,
    parameter int WORDS_PER_OBJ = 3,
    parameter int MAX_TIME      = 60,
    parameter int TARGET_BASE   = 500,
    parameter int TARGET_STEP   = 250
) (
    input  logic            clk,
    input  logic            reset,
    stage_sequencer_if.slave bus
);

    localparam int N   = OBJECTS_COUNT * WORDS_PER_OBJ;
    localparam int K_W = $clog2(N + 1);
    localparam logic [K_W-1:0] K_LAST     = K_W'(N);
    localparam logic [K_W-1:0] K_LAST_ADDR = K_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, PLAY, CHECK, WAIT_NEXT, FAILED, DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [K_W-1:0] k_reg, k_next;
    logic [11:0]    rom_addr_reg, rom_addr_next;
    logic           load_we_reg, load_we_next;
    logic [5:0]     load_idx_reg, load_idx_next;
    logic           level_enable_reg, level_enable_next;
    logic [1:0]     level_reg, level_next;
    logic [8:0]     time_left_reg, time_left_next;
    logic [15:0]    stage_score_reg, stage_score_next;
    logic [15:0]    total_score_reg, total_score_next;
    logic           stage_ended_reg, stage_ended_next;
    logic           stage_failed_reg, stage_failed_next;
    logic           last_level_ended_reg, last_level_ended_next;

    logic [31:0]    target;
    logic           passed;
    logic           on_last_level;
    logic           restart;

    // First ROM word of a level's object table.
    function automatic logic [11:0] level_base(input logic [1:0] lvl);
        return 12'(32'(lvl) * N);
    endfunction

    // Score accumulation clamps at the top of the 16-bit range.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [9:0] v);
        logic [16:0] s;
        s = {1'b0, a} + {7'b0, v};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign target        = 32'(TARGET_BASE) + 32'(level_reg) * 32'(TARGET_STEP);
    assign passed        = (32'(stage_score_reg) >= target);
    assign on_last_level = (32'(level_reg) == 32'(MAX_LEVEL - 1));
    assign restart       = bus.startGame &&
                           (state_reg == IDLE || state_reg == FAILED || state_reg == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state decision.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (bus.startGame) state_next = LOAD;
            LOAD:      if (k_reg == K_LAST) state_next = PLAY;
            PLAY:      if (bus.oneSecPulse && time_left_reg == 9'd0) state_next = CHECK;
            CHECK:     state_next = passed ? (on_last_level ? DONE : WAIT_NEXT) : FAILED;
            WAIT_NEXT: if (bus.cycleLevel) state_next = LOAD;
            FAILED:    if (bus.startGame) state_next = LOAD;
            DONE:      if (bus.startGame) state_next = LOAD;
            default:   state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        k_next                = k_reg;
        rom_addr_next         = rom_addr_reg;
        load_we_next          = 1'b0;
        load_idx_next         = load_idx_reg;
        level_next            = level_reg;
        time_left_next        = time_left_reg;
        stage_score_next      = stage_score_reg;
        total_score_next      = total_score_reg;

        if (restart) begin
            level_next       = 2'd0;
            total_score_next = 16'd0;
        end
        if (state_reg == WAIT_NEXT && bus.cycleLevel)
            level_next = level_reg + 2'd1;

        // Entering LOAD: fresh stage, first address of the new level.
        if (state_reg != LOAD && state_next == LOAD) begin
            k_next           = '0;
            stage_score_next = 16'd0;
            rom_addr_next    = level_base(level_next);
        end

        if (state_reg == LOAD) begin
            // Write strobe trails the address by one cycle to match ROM latency.
            load_we_next  = (k_reg != K_LAST);
            load_idx_next = 6'(k_reg);
            if (k_reg != K_LAST)
                k_next = k_reg + K_W'(1);
            if (k_reg < K_LAST_ADDR)
                rom_addr_next = rom_addr_reg + 12'd1;
            if (k_reg == K_LAST)
                time_left_next = 9'(MAX_TIME);
        end

        if (state_reg == PLAY) begin
            if (bus.scoreValid) begin
                stage_score_next = sat_add(stage_score_reg, bus.scoreValue);
                total_score_next = sat_add(total_score_reg, bus.scoreValue);
            end
            if (bus.oneSecPulse && time_left_reg != 9'd0)
                time_left_next = time_left_reg - 9'd1;
        end

        level_enable_next     = (state_next == PLAY);
        stage_ended_next      = (state_reg == CHECK) && (state_next == WAIT_NEXT);
        stage_failed_next     = (state_next == FAILED);
        last_level_ended_next = (state_next == DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg                <= '0;
            rom_addr_reg         <= 12'd0;
            load_we_reg          <= 1'b0;
            load_idx_reg         <= 6'd0;
            level_enable_reg     <= 1'b0;
            level_reg            <= 2'd0;
            time_left_reg        <= 9'd0;
            stage_score_reg      <= 16'd0;
            total_score_reg      <= 16'd0;
            stage_ended_reg      <= 1'b0;
            stage_failed_reg     <= 1'b0;
            last_level_ended_reg <= 1'b0;
        end else begin
            k_reg                <= k_next;
            rom_addr_reg         <= rom_addr_next;
            load_we_reg          <= load_we_next;
            load_idx_reg         <= load_idx_next;
            level_enable_reg     <= level_enable_next;
            level_reg            <= level_next;
            time_left_reg        <= time_left_next;
            stage_score_reg      <= stage_score_next;
            total_score_reg      <= total_score_next;
            stage_ended_reg      <= stage_ended_next;
            stage_failed_reg     <= stage_failed_next;
            last_level_ended_reg <= last_level_ended_next;
        end
    end

    assign bus.romAddr        = rom_addr_reg;
    assign bus.loadWe         = load_we_reg;
    assign bus.loadIdx        = load_idx_reg;
    // ROM data is already aligned with the write strobe; gate it so the
    // table port reads zero whenever no write is in progress.
    assign bus.loadData       = load_we_reg ? bus.romData : 9'd0;
    assign bus.levelEnable    = level_enable_reg;
    assign bus.currentLevel   = level_reg;
    assign bus.timeLeft       = time_left_reg;
    assign bus.stageScore     = stage_score_reg;
    assign bus.totalScore     = total_score_reg;
    assign bus.stageEnded     = stage_ended_reg;
    assign bus.stageFailed    = stage_failed_reg;
    assign bus.lastLevelEnded = last_level_ended_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: small configuration (6 ROM words per
// level, 2 levels, 3-second stages, targets 10/15) with ROM word i = i.
module tb_stage_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    stage_sequencer_if sif();

    stage_sequencer #(
        .MAX_LEVEL    (2),
        .OBJECTS_COUNT(2),
        .WORDS_PER_OBJ(3),
        .MAX_TIME     (3),
        .TARGET_BASE  (10),
        .TARGET_STEP  (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level ROM: one-cycle registered read, contents equal to the address.
    always @(posedge clk) sif.romData <= sif.romAddr[8:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        sif.startGame = 1'b1;
        tick();
        sif.startGame = 1'b0;
        $display("txn startGame");
    endtask

    task automatic pulse_cycle();
        sif.cycleLevel = 1'b1;
        tick();
        sif.cycleLevel = 1'b0;
        $display("txn cycleLevel");
    endtask

    // Called at LOAD cycle 0; returns in the first PLAY cycle.
    task automatic run_load(input string tag, input int base);
        for (int c = 0; c <= 6; c++) begin
            if (c < 6)
                check($sformatf("%s romAddr c%0d", tag, c), 32'(sif.romAddr), 32'(base + c));
            if (c == 0) begin
                check($sformatf("%s loadWe c0", tag), 32'(sif.loadWe), 32'd0);
            end else begin
                check($sformatf("%s loadWe c%0d", tag, c), 32'(sif.loadWe), 32'd1);
                check($sformatf("%s loadIdx c%0d", tag, c), 32'(sif.loadIdx), 32'(c - 1));
                check($sformatf("%s loadData c%0d", tag, c), 32'(sif.loadData), 32'(base + c - 1));
            end
            check($sformatf("%s levelEnable c%0d", tag, c), 32'(sif.levelEnable), 32'd0);
            tick();
        end
        check({tag, " play levelEnable"}, 32'(sif.levelEnable), 32'd1);
        check({tag, " play loadWe"}, 32'(sif.loadWe), 32'd0);
        check({tag, " play timeLeft"}, 32'(sif.timeLeft), 32'd3);
    endtask

    // Called in PLAY with timeLeft=3: two score strobes, then four
    // second ticks. Returns in the CHECK cycle.
    task automatic run_stage(input string tag, input int a, input int b, input int exp_score);
        sif.scoreValid = 1'b1;
        sif.scoreValue = 10'(a);
        tick();
        $display("txn score %0d", a);
        sif.scoreValue = 10'(b);
        tick();
        $display("txn score %0d", b);
        sif.scoreValid = 1'b0;
        sif.scoreValue = 10'd0;
        check({tag, " stageScore"}, 32'(sif.stageScore), 32'(exp_score));
        for (int p = 1; p <= 4; p++) begin
            sif.oneSecPulse = 1'b1;
            tick();
            sif.oneSecPulse = 1'b0;
            $display("txn oneSecPulse %0d", p);
            check($sformatf("%s timeLeft p%0d", tag, p), 32'(sif.timeLeft), 32'((p < 3) ? 3 - p : 0));
        end
        check({tag, " check levelEnable"}, 32'(sif.levelEnable), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        sif.startGame   = 1'b0;
        sif.cycleLevel  = 1'b0;
        sif.oneSecPulse = 1'b0;
        sif.scoreValid  = 1'b0;
        sif.scoreValue  = 10'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: reset state, then first load.
        check("rst romAddr", 32'(sif.romAddr), 32'd0);
        check("rst loadWe", 32'(sif.loadWe), 32'd0);
        check("rst levelEnable", 32'(sif.levelEnable), 32'd0);
        check("rst currentLevel", 32'(sif.currentLevel), 32'd0);
        check("rst timeLeft", 32'(sif.timeLeft), 32'd0);
        check("rst totalScore", 32'(sif.totalScore), 32'd0);
        check("rst flags", {29'd0, sif.stageEnded, sif.stageFailed, sif.lastLevelEnded}, 32'd0);
        pulse_start();
        run_load("t1", 0);

        // 2: score 4+6, countdown, pass level 0.
        run_stage("t2", 4, 6, 10);
        check("t2 stageEnded in CHECK", 32'(sif.stageEnded), 32'd0);
        tick();
        check("t2 stageEnded pulse", 32'(sif.stageEnded), 32'd1);
        check("t2 levelEnable", 32'(sif.levelEnable), 32'd0);
        tick();
        check("t2 stageEnded cleared", 32'(sif.stageEnded), 32'd0);
        check("t2 totalScore", 32'(sif.totalScore), 32'd10);

        // 3: level 1, score 14 < 15 fails.
        pulse_cycle();
        check("t3 currentLevel", 32'(sif.currentLevel), 32'd1);
        check("t3 stageScore", 32'(sif.stageScore), 32'd0);
        check("t3 totalScore", 32'(sif.totalScore), 32'd10);
        run_load("t3", 6);
        run_stage("t3", 14, 0, 14);
        tick();
        check("t3 stageFailed", 32'(sif.stageFailed), 32'd1);
        check("t3 lastLevelEnded", 32'(sif.lastLevelEnded), 32'd0);
        check("t3 stageEnded", 32'(sif.stageEnded), 32'd0);
        tick();
        tick();
        check("t3 stageFailed held", 32'(sif.stageFailed), 32'd1);

        // 4: restart, pass level 0, then level 1 with exactly 15.
        pulse_start();
        check("t4 stageFailed cleared", 32'(sif.stageFailed), 32'd0);
        check("t4 currentLevel", 32'(sif.currentLevel), 32'd0);
        check("t4 totalScore", 32'(sif.totalScore), 32'd0);
        run_load("t4a", 0);
        run_stage("t4a", 10, 0, 10);
        tick();
        check("t4a stageEnded", 32'(sif.stageEnded), 32'd1);
        pulse_cycle();
        run_load("t4b", 6);
        run_stage("t4b", 7, 8, 15);
        tick();
        check("t4 lastLevelEnded", 32'(sif.lastLevelEnded), 32'd1);
        check("t4 stageEnded none", 32'(sif.stageEnded), 32'd0);
        check("t4 totalScore 25", 32'(sif.totalScore), 32'd25);
        tick();
        tick();
        check("t4 lastLevelEnded held", 32'(sif.lastLevelEnded), 32'd1);
        pulse_start();
        check("t4 restart level", 32'(sif.currentLevel), 32'd0);
        check("t4 restart total", 32'(sif.totalScore), 32'd0);
        check("t4 restart romAddr", 32'(sif.romAddr), 32'd0);
        check("t4 restart lastLevelEnded", 32'(sif.lastLevelEnded), 32'd0);

        // 5: reset in LOAD cycle 3.
        tick();
        tick();
        tick();
        check("t5 pre loadWe", 32'(sif.loadWe), 32'd1);
        check("t5 pre loadIdx", 32'(sif.loadIdx), 32'd2);
        reset = 1'b1;
        #1;
        $display("txn reset asserted mid-load");
        check("t5 romAddr", 32'(sif.romAddr), 32'd0);
        check("t5 loadWe", 32'(sif.loadWe), 32'd0);
        check("t5 loadIdx", 32'(sif.loadIdx), 32'd0);
        check("t5 loadData", 32'(sif.loadData), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5 idle loadWe %0d", i), 32'(sif.loadWe), 32'd0);
        end
        pulse_start();
        run_load("t5", 0);

        // 6: final tick coincident with a 10-point strobe.
        for (int p = 1; p <= 3; p++) begin
            sif.oneSecPulse = 1'b1;
            tick();
            sif.oneSecPulse = 1'b0;
            $display("txn oneSecPulse %0d", p);
        end
        check("t6 timeLeft 0", 32'(sif.timeLeft), 32'd0);
        check("t6 stageScore 0", 32'(sif.stageScore), 32'd0);
        sif.oneSecPulse = 1'b1;
        sif.scoreValid  = 1'b1;
        sif.scoreValue  = 10'd10;
        tick();
        sif.oneSecPulse = 1'b0;
        sif.scoreValid  = 1'b0;
        sif.scoreValue  = 10'd0;
        $display("txn final pulse + score 10");
        check("t6 stageScore", 32'(sif.stageScore), 32'd10);
        check("t6 levelEnable", 32'(sif.levelEnable), 32'd0);
        check("t6 timeLeft stays 0", 32'(sif.timeLeft), 32'd0);
        tick();
        check("t6 stageEnded", 32'(sif.stageEnded), 32'd1);
        check("t6 stageFailed", 32'(sif.stageFailed), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
